// File: rtl/snake_pkg.sv
// snake_pkg: direction codes shared by the snake steering path.
package snake_pkg;
   localparam int DIR_W = 2;
   typedef enum logic [DIR_W-1:0] {
      DIR_RIGHT = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_UP    = 2'b11
   } dir_t;
   function automatic logic [DIR_W-1:0] opposite(input logic [DIR_W-1:0] d);
      return d ^ 2'b10;
   endfunction
endpackage

// File: rtl/snake_turn_queue_if.sv
// snake_turn_queue_if: button/tick inputs and heading/queue status of the turn queue.
interface snake_turn_queue_if #(parameter int QUEUE_DEPTH = 4);
   import snake_pkg::*;
   localparam int CW = $clog2(QUEUE_DEPTH) + 1;
   logic [3:0]       btn;
   logic             game_tik;
   logic             clear;
   logic [DIR_W-1:0] dir;
   logic             right;
   logic             left;
   logic             up;
   logic             down;
   logic [3:0]       press;
   logic [CW-1:0]    q_count;
   logic             overflow;
   modport master (output btn, game_tik, clear,
                   input dir, right, left, up, down, press, q_count, overflow);
   modport slave  (input btn, game_tik, clear,
                   output dir, right, left, up, down, press, q_count, overflow);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stability counter and registered rising-edge pulse for one button.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W = 18
) (
   input  logic clock_25,
   input  logic reset,
   input  logic raw,
   output logic press
);
   logic s1, s2, db, db_d;
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clock_25 or negedge reset)
      if (!reset) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         db    <= 1'b0;
         db_d  <= 1'b0;
         press <= 1'b0;
         cnt   <= '0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         db_d  <= db;
         press <= db & ~db_d;
         if (s2 == db) cnt <= '0;
         else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db  <= ~db;
            cnt <= '0;
         end else cnt <= cnt + 1'b1;
      end
endmodule

// File: rtl/snake_turn_queue.sv
// snake_turn_queue: debounced buttons -> direction requests -> turn queue, one turn applied per game_tik.
// Define TURN_QUEUE_STATS_EN to add the saturating drop_count output.
module snake_turn_queue
   import snake_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W = 18,
   parameter int QUEUE_DEPTH = 4,
   parameter int ABSOLUTE_MODE = 0
) (
   input  logic clock_25,
   input  logic reset,
   snake_turn_queue_if.slave bus
`ifdef TURN_QUEUE_STATS_EN
   ,
   output logic [7:0] drop_count
`endif
);
   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(QUEUE_DEPTH);
   logic [3:0] press;
   logic [DIR_W-1:0] mem [QUEUE_DEPTH];
   logic [DIR_W-1:0] dir, tail_dir, abs_dir, req_dir;
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [PW:0] count;
   logic req_valid, pop, push, drop, overflow;
   genvar i;
   for (i = 0; i < 4; i++) begin : g_db
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
         .clock_25(clock_25),
         .reset(reset),
         .raw(bus.btn[i]),
         .press(press[i])
      );
   end
   // Requests are judged against the newest queued turn so back-to-back taps chain correctly.
   always_comb begin
      tail_dir  = count == '0 ? dir : mem[wr_ptr - 1'b1];
      abs_dir   = press[0] ? DIR_RIGHT : press[1] ? DIR_LEFT : press[2] ? DIR_UP : DIR_DOWN;
      req_dir   = ABSOLUTE_MODE != 0 ? abs_dir : press[0] ? tail_dir + 1'b1 : tail_dir - 1'b1;
      req_valid = ABSOLUTE_MODE != 0 ? |press && abs_dir != tail_dir && abs_dir != opposite(tail_dir)
                                     : |press[1:0];
      pop       = bus.game_tik && count != '0;
      push      = req_valid && (count != FULL || pop);
      drop      = req_valid && count == FULL && !pop;
   end
   always_ff @(posedge clock_25 or negedge reset)
      if (!reset) begin
         dir      <= DIR_RIGHT;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (bus.clear) begin
         dir      <= DIR_RIGHT;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= drop;
         if (pop) begin
            dir    <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
   always_ff @(posedge clock_25)
      if (push && !bus.clear) mem[wr_ptr] <= req_dir;
`ifdef TURN_QUEUE_STATS_EN
   always_ff @(posedge clock_25 or negedge reset)
      if (!reset) drop_count <= '0;
      else if (bus.clear) drop_count <= '0;
      else if (drop && drop_count != 8'hff) drop_count <= drop_count + 1'b1;
`endif
   assign bus.dir      = dir;
   assign bus.right    = dir == DIR_RIGHT;
   assign bus.down     = dir == DIR_DOWN;
   assign bus.left     = dir == DIR_LEFT;
   assign bus.up       = dir == DIR_UP;
   assign bus.press    = press;
   assign bus.q_count  = count;
   assign bus.overflow = overflow;
endmodule

// File: tb/tb_snake_turn_queue.sv
// tb_snake_turn_queue: directed bench for relative and absolute turn queues with an expected-heading scoreboard.
module tb_snake_turn_queue;
   localparam int D = 8;
   localparam int QD = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   snake_turn_queue_if #(.QUEUE_DEPTH(QD)) r_if ();
   snake_turn_queue_if #(.QUEUE_DEPTH(QD)) a_if ();
`ifdef TURN_QUEUE_STATS_EN
   logic [7:0] r_drops, a_drops;
`endif
   snake_turn_queue #(.DEBOUNCE_CYCLES(D), .CNT_W(4), .QUEUE_DEPTH(QD), .ABSOLUTE_MODE(0)) u_rel (
      .clock_25(clk),
      .reset(rst_n),
      .bus(r_if)
`ifdef TURN_QUEUE_STATS_EN
      ,
      .drop_count(r_drops)
`endif
   );
   snake_turn_queue #(.DEBOUNCE_CYCLES(D), .CNT_W(4), .QUEUE_DEPTH(QD), .ABSOLUTE_MODE(1)) u_abs (
      .clock_25(clk),
      .reset(rst_n),
      .bus(a_if)
`ifdef TURN_QUEUE_STATS_EN
      ,
      .drop_count(a_drops)
`endif
   );
   int checks = 0;
   int errors = 0;
   logic [1:0] sb[$];
   logic [1:0] model_dir = 2'b00;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic logic [1:0] amap(input int b);
      return b == 0 ? 2'b00 : b == 1 ? 2'b10 : b == 2 ? 2'b11 : 2'b01;
   endfunction
   function automatic logic [31:0] f_dir(input bit ab);
      return ab ? 32'(a_if.dir) : 32'(r_if.dir);
   endfunction
   function automatic logic [31:0] f_qc(input bit ab);
      return ab ? 32'(a_if.q_count) : 32'(r_if.q_count);
   endfunction
   function automatic logic [31:0] f_ov(input bit ab);
      return ab ? 32'(a_if.overflow) : 32'(r_if.overflow);
   endfunction
   function automatic logic [31:0] f_press(input bit ab);
      return ab ? 32'(a_if.press) : 32'(r_if.press);
   endfunction
   function automatic logic [31:0] f_hot(input bit ab);
      return ab ? 32'({a_if.up, a_if.left, a_if.down, a_if.right})
                : 32'({r_if.up, r_if.left, r_if.down, r_if.right});
   endfunction
   task automatic tik(input bit ab);
      if (ab) a_if.game_tik = 1'b1; else r_if.game_tik = 1'b1;
      @(negedge clk);
      a_if.game_tik = 1'b0;
      r_if.game_tik = 1'b0;
      if (sb.size() > 0) model_dir = sb.pop_front();
      check("tik_dir", f_dir(ab), 32'(model_dir));
      check("tik_onehot", f_hot(ab), 32'(4'b0001 << model_dir));
      check("tik_q_count", f_qc(ab), 32'(sb.size()));
   endtask
   // Press button b until its debounced pulse shows, optionally with a game_tik on the enqueue edge.
   task automatic do_press(input bit ab, input int b, input bit with_tik);
      logic [1:0] tail, req;
      bit vld, seen, exp_ov;
      tail = sb.size() > 0 ? sb[$] : model_dir;
      req  = ab ? amap(b) : (b == 0 ? tail + 2'd1 : tail - 2'd1);
      vld  = ab ? (req != tail && req != (tail ^ 2'b10)) : (b < 2);
      if (ab) a_if.btn[b] = 1'b1; else r_if.btn[b] = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         seen = f_press(ab)[b];
      end
      check("press_seen", 32'(seen), 32'd1);
      if (with_tik) begin
         if (ab) a_if.game_tik = 1'b1; else r_if.game_tik = 1'b1;
      end
      @(negedge clk);
      a_if.game_tik = 1'b0;
      r_if.game_tik = 1'b0;
      if (with_tik) begin
         if (sb.size() > 0) model_dir = sb.pop_front();
         check("push_tik_dir", f_dir(ab), 32'(model_dir));
      end
      exp_ov = vld && sb.size() == QD;
      if (vld && !exp_ov) sb.push_back(req);
      check("overflow", f_ov(ab), 32'(exp_ov));
      if (ab) a_if.btn[b] = 1'b0; else r_if.btn[b] = 1'b0;
      repeat (14) @(negedge clk);
      check("q_count", f_qc(ab), 32'(sb.size()));
   endtask
   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end
   initial begin
      bit seen;
      r_if.btn = '0; r_if.game_tik = 1'b0; r_if.clear = 1'b0;
      a_if.btn = '0; a_if.game_tik = 1'b0; a_if.clear = 1'b0;
      repeat (3) @(negedge clk);
      for (int ab = 0; ab < 2; ab++) begin
         check("rst_dir", f_dir(ab[0]), 32'd0);
         check("rst_onehot", f_hot(ab[0]), 32'd1);
         check("rst_q_count", f_qc(ab[0]), 32'd0);
         check("rst_press", f_press(ab[0]), 32'd0);
         check("rst_overflow", f_ov(ab[0]), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      // Short glitch must never reach the queue.
      r_if.btn[0] = 1'b1;
      seen = 1'b0;
      repeat (5) begin @(negedge clk); seen |= r_if.press[0]; end
      r_if.btn[0] = 1'b0;
      repeat (20) begin @(negedge clk); seen |= r_if.press[0]; end
      check("glitch_press", 32'(seen), 32'd0);
      check("glitch_q_count", f_qc(0), 32'd0);
      check("glitch_dir", f_dir(0), 32'd0);
      do_press(0, 0, 0);
      tik(0);
      do_press(0, 0, 0);
      do_press(0, 0, 0);
      tik(0);
      tik(0);
      tik(0);
      do_press(0, 1, 0);
      tik(0);
      repeat (5) do_press(0, 0, 0);
`ifdef TURN_QUEUE_STATS_EN
      check("drop_count", 32'(r_drops), 32'd1);
`endif
      do_press(0, 0, 1);
      repeat (4) tik(0);
      do_press(0, 2, 0);
      do_press(0, 3, 0);
      repeat (3) do_press(0, 1, 0);
      r_if.clear = 1'b1;
      @(negedge clk);
      r_if.clear = 1'b0;
      sb.delete();
      model_dir = 2'b00;
      check("clear_q_count", f_qc(0), 32'd0);
      check("clear_dir", f_dir(0), 32'd0);
      check("clear_onehot", f_hot(0), 32'd1);
`ifdef TURN_QUEUE_STATS_EN
      check("clear_drop_count", 32'(r_drops), 32'd0);
`endif
      do_press(1, 1, 0);
      do_press(1, 0, 0);
      do_press(1, 2, 0);
      tik(1);
      do_press(1, 3, 0);
      do_press(1, 1, 0);
      tik(1);
      do_press(1, 2, 1);
      tik(1);
      sb.delete();
      model_dir = 2'b00;
      // Asynchronous reset in the middle of a debounce with a queued entry.
      do_press(0, 0, 0);
      r_if.btn[0] = 1'b1;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_q_count", f_qc(0), 32'd0);
      check("async_rst_dir", f_dir(0), 32'd0);
      check("async_rst_onehot", f_hot(0), 32'd1);
      check("async_rst_press", f_press(0), 32'd0);
      check("async_rst_overflow", f_ov(0), 32'd0);
      check("async_rst_abs_dir", f_dir(1), 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (D) begin @(negedge clk); seen |= r_if.press[0]; end
      check("held_early_press", 32'(seen), 32'd0);
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         seen = r_if.press[0];
      end
      check("held_late_press", 32'(seen), 32'd1);
      r_if.btn[0] = 1'b0;
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/snake_turn_queue.md
Name: snake_turn_queue

Overview:
- Parametrised successor to the two-button right/left steering path: synchronises, debounces and edge-detects up to four push-buttons, then converts presses into direction requests.
- Requests are buffered in a small turn queue. One request is applied per game_tik, so fast double-taps between ticks are not lost.
- Drives the current heading to the snake movement logic. Supports relative steering (rotate left/right) and absolute steering (4 buttons).

Parameters:
DEBOUNCE_CYCLES, 250000, clock_25 cycles a synchronised level must stay stable before it is accepted (10 ms at 25 MHz)
CNT_W, 18, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES
QUEUE_DEPTH, 4, turn-queue entries; power of two, 2..16
ABSOLUTE_MODE, 0, 0 = relative (btn[0]=turn right, btn[1]=turn left, btn[3:2] ignored); 1 = absolute (btn[0]=RIGHT, btn[1]=LEFT, btn[2]=UP, btn[3]=DOWN)

Ports:
clock_25  in  1  system clock, 25 MHz
reset  in  1  asynchronous, active-low
btn  in  4  raw asynchronous push-buttons, active-high
game_tik  in  1  one-cycle movement strobe
clear  in  1  synchronous game restart: flush queue, heading to RIGHT
dir  out  2  current heading: 00 RIGHT, 01 DOWN, 10 LEFT, 11 UP (clockwise order)
right, left, up, down  out  1 each  one-hot decode of dir
press  out  4  one-cycle debounced rising-edge pulses, for debug and score logic
q_count  out  $clog2(QUEUE_DEPTH)+1  entries currently queued
overflow  out  1  one-cycle pulse when a request is dropped

Behaviour:
- Reset (reset=0), asynchronous: dir=00, right=1, others 0, press=0, q_count=0, overflow=0, sync/debounce state=0, tail_dir=00.
- Synchroniser: per-bit 2-FF chain. Debouncer: per-bit counter.
  - Counter resets to 0 when the synchronised level equals the debounced level.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES-1, the debounced level toggles and the counter clears.
- press[i] = debounced rising edge, registered.
- Latency: button stable high from edge 0 → press[i] high after 2+DEBOUNCE_CYCLES+1 edges; enqueue on the edge after press.
- Request selection when several press bits are set in one cycle: lowest index wins, the rest are discarded (no overflow pulse).
- tail_dir = direction of the newest queued entry, or dir when the queue is empty.
- Relative mode: right → tail_dir+1 mod 4; left → tail_dir-1 mod 4. Always valid.
- Absolute mode: a request is rejected silently if equal to tail_dir or opposite to it (tail_dir ^ 2'b10).
- Queue: circular buffer with rd/wr pointers and a count.
  - Valid request while count==QUEUE_DEPTH and no pop this cycle → drop, overflow=1 for one cycle.
  - Pop on game_tik when count>0: dir ← head entry, visible on the edge after game_tik.
  - game_tik with an empty queue: dir holds.
  - Push and pop in the same cycle: both occur, count unchanged. If full, the push is accepted (pop frees a slot). If empty, the push is written and not popped; it pops on the next tik.
- clear has priority over push/pop: count=0, pointers=0, dir=00. Debouncer state is kept; a press in the clear cycle is discarded.
- Reset mid-debounce or mid-queue: everything returns to reset values immediately. Any button held through reset needs a full debounce interval after release of reset before it registers.

Optional Feature:
TURN_QUEUE_STATS_EN:
- Defined: adds output drop_count (8 bits). It increments on each overflow pulse, saturates at 255, and clears on reset or clear.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package snake_pkg: direction codes DIR_RIGHT/DIR_DOWN/DIR_LEFT/DIR_UP, DIR_W=2, function opposite(d)=d^2'b10.
- One sub-module: btn_debounce (per-bit synchroniser + counter + edge pulse, parameters DEBOUNCE_CYCLES, CNT_W), instantiated 4 times.
- Queue and heading logic stay in the top module.

Test Plan:
- Glitch rejection: DEBOUNCE_CYCLES=8, btn[0] high for 5 cycles → no press, q_count=0, dir=00.
- Relative turn: btn[0] held 20 cycles, then game_tik → q_count 1→0, dir=01 (DOWN), down=1.
- Double-tap buffering: right, right before one tik → queued 01, 10; first tik dir=01, second tik dir=10 (LEFT); third tik dir holds.
- Overflow: QUEUE_DEPTH=4, 5 presses without tik → q_count=4, one overflow pulse; with TURN_QUEUE_STATS_EN, drop_count=1. Full queue plus simultaneous push and tik → count stays 4, no overflow.
- Absolute reversal: ABSOLUTE_MODE=1, dir=00, press LEFT → rejected, q_count=0; press UP → queued, tik → dir=11.
- Clear/reset: 3 queued entries, clear pulse → q_count=0, dir=00. reset=0 during a debounce → all outputs return to reset values immediately.
